// File: rtl/pbus_interconnect_pkg.sv
// Shared definitions for the PicoRV32 native-bus interconnect: FSM states,
// address width, default error read data and counter sizing.
package pbus_interconnect_pkg;

  localparam int PBUS_AW = 32;
  localparam logic [31:0] PBUS_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_RESP   = 2'd3
  } pbus_state_e;

  // Bits needed to hold values 0..limit; never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit > 1) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/pbus_interconnect_addr_decode.sv
// Combinational base/mask address matcher. Produces a one-hot select in which
// the lowest-numbered matching slave wins, plus a flag that any slave matched.
module pbus_interconnect_addr_decode
  import pbus_interconnect_pkg::*;
#(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_BASE   = '0,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_MASK   = '0
) (
  input  logic [PBUS_AW-1:0]    addr,
  output logic [NUM_SLAVES-1:0] sel_onehot,
  output logic                  hit
);

  logic [NUM_SLAVES-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign match[gi] = (addr & SLV_MASK[gi*32 +: 32]) == SLV_BASE[gi*32 +: 32];
    end
  endgenerate

  // Walk from the highest index down so the lowest match overwrites last.
  always_comb begin
    sel_onehot = '0;
    hit        = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
        hit           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pbus_interconnect.sv
// One-master / NUM_SLAVES-slave PicoRV32 native-bus interconnect with registered
// decode, per-transfer timeout and error response. Define PBUS_ERR_STATUS_EN to
// build the err_addr / err_count status registers.
module pbus_interconnect
  import pbus_interconnect_pkg::*;
#(
  parameter int                        NUM_SLAVES     = 4,
  parameter int                        DATA_W         = 32,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_BASE       = '0,
  parameter logic [NUM_SLAVES*32-1:0]  SLV_MASK       = '0,
  parameter int                        TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]         ERR_DATA       = DATA_W'(PBUS_ERR_DATA)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_valid,
  input  logic [PBUS_AW-1:0]           m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_ready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic [NUM_SLAVES-1:0]        s_valid,
  output logic [PBUS_AW-1:0]           s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [NUM_SLAVES-1:0]        s_ready,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic                         bus_err,
  output logic [PBUS_AW-1:0]           err_addr,
  output logic [7:0]                   err_count
);

  localparam int              CNT_W       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  pbus_state_e            state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   expire;
  logic [NUM_SLAVES-1:0]  dec_sel;
  logic                   dec_hit;
  logic                   sel_ready;
  logic [DATA_W-1:0]      sel_rdata;

  pbus_interconnect_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_decode (
    .addr       (s_addr),
    .sel_onehot (dec_sel),
    .hit        (dec_hit)
  );

  // s_valid is one-hot while ACTIVE, so it doubles as the response select.
  always_comb begin
    sel_ready = |(s_ready & s_valid);
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (s_valid[i]) begin
        sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cnt_next = cnt_reg + 1'b1;
  assign expire   = TIMEOUT_EN && (cnt_next == TIMEOUT_LIM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      m_ready   <= 1'b0;
      m_rdata   <= '0;
      bus_err   <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses; the RESP entry re-arms them.
      m_ready <= 1'b0;
      m_rdata <= '0;
      bus_err <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (m_valid) begin
            s_addr    <= m_addr;
            s_wdata   <= m_wdata;
            s_wstrb   <= m_wstrb;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (dec_hit) begin
            s_valid   <= dec_sel;
            cnt_reg   <= '0;
            state_reg <= ST_ACTIVE;
          end else begin
            m_ready   <= 1'b1;
            m_rdata   <= ERR_DATA;
            bus_err   <= 1'b1;
            state_reg <= ST_RESP;
          end
        end
        ST_ACTIVE: begin
          if (sel_ready) begin
            s_valid   <= '0;
            m_ready   <= 1'b1;
            m_rdata   <= sel_rdata;
            state_reg <= ST_RESP;
          end else if (expire) begin
            s_valid   <= '0;
            m_ready   <= 1'b1;
            m_rdata   <= ERR_DATA;
            bus_err   <= 1'b1;
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_next;
          end
        end
        ST_RESP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PBUS_ERR_STATUS_EN
  logic err_event;

  // Same conditions that load bus_err, so status updates alongside the pulse.
  assign err_event = ((state_reg == ST_DECODE) && !dec_hit) ||
                     ((state_reg == ST_ACTIVE) && !sel_ready && expire);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_addr  <= '0;
      err_count <= '0;
    end else if (err_event) begin
      err_addr <= s_addr;
      if (err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end
`else
  assign err_addr  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_pbus_interconnect.sv
// Randomized scoreboard bench for pbus_interconnect: a region table gives the
// expected slave per address, a driver queues expectations, a monitor checks.
module tb_pbus_interconnect;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int T  = 8;
  localparam logic [NS*32-1:0] BASES = {32'h0000_8000, 32'h0400_0000, 32'h0200_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hFFFE_8000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic              clk;
  logic              reset;
  logic              m_valid;
  logic [31:0]       m_addr;
  logic [DW-1:0]     m_wdata;
  logic [DW/8-1:0]   m_wstrb;
  logic              m_ready;
  logic [DW-1:0]     m_rdata;
  logic [NS-1:0]     s_valid;
  logic [31:0]       s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_wstrb;
  logic [NS-1:0]     s_ready;
  logic [NS*DW-1:0]  s_rdata;
  logic              bus_err;
  logic [31:0]       err_addr;
  logic [7:0]        err_count;

  pbus_interconnect #(
    .NUM_SLAVES     (NS),
    .DATA_W         (DW),
    .SLV_BASE       (BASES),
    .SLV_MASK       (MASKS),
    .TIMEOUT_CYCLES (T),
    .ERR_DATA       (ERRD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_valid   (m_valid),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_ready   (m_ready),
    .m_rdata   (m_rdata),
    .s_valid   (s_valid),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_ready   (s_ready),
    .s_rdata   (s_rdata),
    .bus_err   (bus_err),
    .err_addr  (err_addr),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          err;
    int          target;
    int          sv_cycles;
    int          latency;
    int          issue_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          cur_lat = 0;
  logic [31:0] slv_data [NS];
  int          err_model_cnt = 0;

  // Memory map as address ranges with the slave that must answer (-1: none).
  int          reg_base [8] = '{32'h0000_0000, 32'h0000_8000, 32'h0200_0000, 32'h0400_0000,
                                32'h0001_8000, 32'h0300_0000, 32'h0200_1000, 32'h0001_0000};
  int          reg_span [8] = '{32'h8000, 32'h8000, 32'h1000, 32'h1000,
                                32'h8000, 32'h10000, 32'h1000, 32'h8000};
  int          reg_tgt  [8] = '{0, 0, 1, 2, 3, -1, -1, -1};
  int          lat_tab  [9] = '{0, 0, 1, 2, 3, 5, 7, 8, 1000};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_err_count();
`ifdef PBUS_ERR_STATUS_EN
    return (err_model_cnt > 255) ? 8'hFF : 8'(err_model_cnt);
`else
    return 8'h00;
`endif
  endfunction

  // Slave responder: selected slave answers after cur_lat wait cycles;
  // unselected slaves toggle s_ready randomly, which the DUT must ignore.
  initial begin
    int act;
    logic [NS-1:0] noise;
    act     = 0;
    s_ready = '0;
    forever begin
      @(posedge clk);
      #1;
      noise = NS'($urandom);
      if (reset) begin
        act     = 0;
        s_ready = '0;
      end else if (s_valid != '0) begin
        act++;
        s_ready = noise & ~s_valid;
        if (act - 1 >= cur_lat) s_ready = s_ready | s_valid;
      end else begin
        act     = 0;
        s_ready = noise;
      end
    end
  end

  // Monitor: tracks slave-side activity and checks each m_ready against the queue.
  initial begin
    logic [NS-1:0] seen;
    int            svc;
    logic [31:0]   err_model_addr;
    exp_t          e;
    seen           = '0;
    svc            = 0;
    err_model_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        seen           = '0;
        svc            = 0;
        err_model_cnt  = 0;
        err_model_addr = '0;
        continue;
      end
      if (s_valid != '0) begin
        seen = seen | s_valid;
        svc++;
        if ($countones(s_valid) != 1) begin
          errors++;
          $display("FAIL s_valid_onehot: got %b expected one bit set", s_valid);
        end
      end
      if (bus_err && !m_ready) begin
        errors++;
        $display("FAIL bus_err_alone: got bus_err=1 m_ready=0 expected bus_err only with m_ready");
      end
      if (m_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_m_ready: got m_ready=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          if (e.err) begin
            err_model_cnt++;
            err_model_addr = e.addr;
          end
          $display("txn addr=%h wstrb=%h rdata=%h bus_err=%b svalid=%b cycles=%0d",
                   e.addr, e.wstrb, m_rdata, bus_err, seen, cyc - e.issue_cyc);
          chk("m_rdata", m_rdata, e.rdata);
          chk("bus_err", 32'(bus_err), 32'(e.err));
          chk("slave_seen", 32'(seen), (e.target >= 0) ? (32'd1 << e.target) : 32'd0);
          chk("svalid_cycles", svc, e.sv_cycles);
          chk("latency", cyc - e.issue_cyc, e.latency);
          chk("s_addr", s_addr, e.addr);
          chk("s_wdata", s_wdata, e.wdata);
          chk("s_wstrb", 32'(s_wstrb), 32'(e.wstrb));
          chk("err_count", 32'(err_count), 32'(exp_err_count()));
`ifdef PBUS_ERR_STATUS_EN
          chk("err_addr", err_addr, err_model_addr);
`else
          chk("err_addr", err_addr, 32'h0);
`endif
        end
        seen = '0;
        svc  = 0;
      end
    end
  end

  task automatic rand_slaves();
    for (int i = 0; i < NS; i++) slv_data[i] = $urandom;
  endtask

  task automatic load_rdata();
    for (int i = 0; i < NS; i++) s_rdata[i*32 +: 32] = slv_data[i];
  endtask

  // Issues one transfer; expected outcome follows from target region and slave latency.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int lat, input int target, input bit drop_early);
    exp_t e;
    bit   got;
    load_rdata();
    cur_lat     = lat;
    e.addr      = addr;
    e.wdata     = wdata;
    e.wstrb     = wstrb;
    e.target    = target;
    e.issue_cyc = cyc;
    if (target < 0) begin
      e.err = 1'b1; e.sv_cycles = 0;   e.latency = 2;
    end else if (lat < T) begin
      e.err = 1'b0; e.sv_cycles = lat + 1; e.latency = 3 + lat;
    end else begin
      e.err = 1'b1; e.sv_cycles = T;   e.latency = 2 + T;
    end
    e.rdata = e.err ? ERRD : slv_data[(target < 0) ? 0 : target];
    exp_q.push_back(e);
    m_addr  = addr;
    m_wdata = wdata;
    m_wstrb = wstrb;
    m_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      #1;
      if (drop_early && k == 0) begin
        m_valid = 1'b0;
        m_addr  = $urandom;
        m_wdata = $urandom;
      end
      if (m_ready) begin
        got = 1'b1;
        break;
      end
    end
    m_valid = 1'b0;
    if (!got) begin
      errors++;
      $display("FAIL handshake_timeout: got no m_ready for addr %h expected a response", addr);
    end
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_m_ready"}, 32'(m_ready), 32'h0);
    chk({tag, "_m_rdata"}, m_rdata, 32'h0);
    chk({tag, "_s_valid"}, 32'(s_valid), 32'h0);
    chk({tag, "_s_addr"}, s_addr, 32'h0);
    chk({tag, "_s_wdata"}, s_wdata, 32'h0);
    chk({tag, "_s_wstrb"}, 32'(s_wstrb), 32'h0);
    chk({tag, "_bus_err"}, 32'(bus_err), 32'h0);
    chk({tag, "_err_addr"}, err_addr, 32'h0);
    chk({tag, "_err_count"}, 32'(err_count), 32'h0);
  endtask

  initial begin
    int r;
    int lat;
    bit waited;
    reset   = 1'b1;
    m_valid = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    s_rdata = '0;
    rand_slaves();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait read of slave1.
    rand_slaves();
    slv_data[1] = 32'h1234_5678;
    do_txn(32'h0200_0000, 32'h0, 4'h0, 0, 1, 1'b0);
    // Byte write to slave2 answered after three s_valid cycles.
    rand_slaves();
    do_txn(32'h0400_0004, 32'h0000_0055, 4'b0001, 2, 2, 1'b0);
    // Unmapped read.
    do_txn(32'h0300_0000, 32'h0, 4'h0, 0, -1, 1'b0);
    // Slave never ready, then ready exactly on the expiry cycle.
    rand_slaves();
    do_txn(32'h0200_0100, 32'h0, 4'h0, 1000, 1, 1'b0);
    rand_slaves();
    do_txn(32'h0200_0104, 32'h0, 4'h0, T - 1, 1, 1'b0);
    // Overlap resolves to slave0; slave3-only space still reaches slave3.
    rand_slaves();
    do_txn(32'h0000_8010, 32'h0, 4'h0, 1, 0, 1'b0);
    rand_slaves();
    do_txn(32'h0001_8010, 32'hA5A5_5A5A, 4'hF, 0, 3, 1'b1);

    // Asynchronous reset while a transfer sits in ACTIVE.
    rand_slaves();
    load_rdata();
    cur_lat = 1000;
    m_addr  = 32'h0200_0010;
    m_wstrb = 4'h0;
    m_valid = 1'b1;
    waited  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (s_valid != '0) begin
        waited = 1'b1;
        break;
      end
    end
    if (!waited) begin
      errors++;
      $display("FAIL reset_setup: got no s_valid expected s_valid within 10 cycles");
    end
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    m_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    rand_slaves();
    do_txn(32'h0200_0020, 32'h0, 4'h0, 1, 1, 1'b0);

    // Drive the error counter past saturation.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(5, 7);
      do_txn(reg_base[r] + ($urandom_range(0, reg_span[r] - 1) & ~32'd3), $urandom,
             4'($urandom), 0, -1, ($urandom_range(0, 3) == 0));
    end
    @(posedge clk);
    #1;
`ifdef PBUS_ERR_STATUS_EN
    chk("err_count_saturated", 32'(err_count), 32'h0000_00FF);
`else
    chk("err_count_saturated", 32'(err_count), 32'h0);
`endif

    // Random mix over the whole map.
    for (int n = 0; n < 150; n++) begin
      r   = $urandom_range(0, 7);
      lat = lat_tab[$urandom_range(0, 8)];
      rand_slaves();
      do_txn(reg_base[r] + ($urandom_range(0, reg_span[r] - 1) & ~32'd3), $urandom,
             ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), lat, reg_tgt[r],
             ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expectations: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
